// File: rtl/asmd_mult_acc_if.sv
// Bus bundle for the shift-add multiplier-accumulator.
//   master : controller side, drives operands, mode bits, start and clear_acc
//   slave  : arithmetic unit side, returns product, ready, done and acc_ovf
interface asmd_mult_acc_if #(
  parameter int word_length = 10
);
  logic [word_length-1:0]   word0;
  logic [word_length-1:0]   word1;
  logic                     start;
  logic                     signed_mode;
  logic                     accumulate;
  logic                     clear_acc;
  logic [2*word_length-1:0] product;
  logic                     ready;
  logic                     done;
  logic                     acc_ovf;

  modport master (
    output word0, word1, start, signed_mode, accumulate, clear_acc,
    input  product, ready, done, acc_ovf
  );

  modport slave (
    input  word0, word1, start, signed_mode, accumulate, clear_acc,
    output product, ready, done, acc_ovf
  );
endinterface

// File: rtl/asmd_mult_acc.sv
// Sequential shift-add multiplier-accumulator (IDLE -> MUL -> FIX).
// Operands are converted to magnitudes on start, multiplied one multiplier
// bit per cycle LSB first, then the sign is restored and the result is either
// loaded into or added onto the product register.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : asmd_mult_acc_if.slave (word0/word1/start/signed_mode/accumulate/
//           clear_acc in; product/ready/done/acc_ovf out, all registered)
// Parameters:
//   word_length : operand width W (>= 2), product width 2W
//   early_exit  : 1 = stop MUL once the remaining multiplier bits are zero
module asmd_mult_acc #(
  parameter int word_length = 10,
  parameter bit early_exit  = 1'b1
) (
  input logic            clk,
  input logic            reset,
  asmd_mult_acc_if.slave bus
);
  localparam int W  = word_length;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t        state_r;
  logic [PW-1:0] mcand_r;
  logic [PW-1:0] partial_r;
  logic [PW-1:0] product_r;
  logic [W-1:0]  mplier_r;
  logic [CW-1:0] bit_cnt_r;
  logic          negate_r;
  logic          signed_r;
  logic          accumulate_r;
  logic          zero_base_r;
  logic          ready_r;
  logic          done_r;
  logic          acc_ovf_r;

  logic [PW-1:0] result_s;
  logic [PW-1:0] base_s;
  logic [PW-1:0] sum_s;
  logic          ovf_base_s;
  logic          last_bit_s;

  // Unsigned magnitude of a W-bit operand; the most negative value maps to 2^(W-1).
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] w, input logic is_signed);
    if (is_signed && w[W-1]) begin
      magnitude = (~w) + {{(W-1){1'b0}}, 1'b1};
    end else begin
      magnitude = w;
    end
  endfunction

  // Overflow of a 2W-bit addition: carry out when unsigned, sign flip when signed.
  function automatic logic add_overflow(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                        input logic is_signed);
    logic [PW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (is_signed) begin
      add_overflow = (a[PW-1] == b[PW-1]) && (sum[PW-1] != a[PW-1]);
    end else begin
      add_overflow = sum[PW];
    end
  endfunction

  // Result fix-up, accumulation base and MUL termination condition.
  always_comb begin
    result_s   = {PW{1'b0}};
    base_s     = {PW{1'b0}};
    ovf_base_s = 1'b0;
    if (negate_r) begin
      result_s = (~partial_r) + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      result_s = partial_r;
    end
    // A clear_acc seen together with start makes this op accumulate onto zero.
    if (zero_base_r) begin
      base_s     = {PW{1'b0}};
      ovf_base_s = 1'b0;
    end else begin
      base_s     = product_r;
      ovf_base_s = acc_ovf_r;
    end
    sum_s = base_s + result_s;
    // The bit in flight is the last one if it is bit W-1, or if nothing set remains above it.
    last_bit_s = (bit_cnt_r == CW'(W - 1)) ||
                 (early_exit && (mplier_r[W-1:1] == {(W-1){1'b0}}));
  end

  // Controller FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      mcand_r      <= {PW{1'b0}};
      partial_r    <= {PW{1'b0}};
      product_r    <= {PW{1'b0}};
      mplier_r     <= {W{1'b0}};
      bit_cnt_r    <= {CW{1'b0}};
      negate_r     <= 1'b0;
      signed_r     <= 1'b0;
      accumulate_r <= 1'b0;
      zero_base_r  <= 1'b0;
      ready_r      <= 1'b1;
      done_r       <= 1'b0;
      acc_ovf_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mcand_r      <= {{W{1'b0}}, magnitude(bus.word0, bus.signed_mode)};
            mplier_r     <= magnitude(bus.word1, bus.signed_mode);
            partial_r    <= {PW{1'b0}};
            bit_cnt_r    <= {CW{1'b0}};
            negate_r     <= bus.signed_mode & (bus.word0[W-1] ^ bus.word1[W-1]);
            signed_r     <= bus.signed_mode;
            accumulate_r <= bus.accumulate;
            zero_base_r  <= bus.clear_acc;
            ready_r      <= 1'b0;
            state_r      <= MUL;
          end else if (bus.clear_acc) begin
            product_r <= {PW{1'b0}};
            acc_ovf_r <= 1'b0;
          end
        end
        MUL: begin
          if (mplier_r[0]) begin
            partial_r <= partial_r + mcand_r;
          end
          mcand_r   <= {mcand_r[PW-2:0], 1'b0};
          mplier_r  <= {1'b0, mplier_r[W-1:1]};
          bit_cnt_r <= bit_cnt_r + CW'(1);
          if (last_bit_s) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (accumulate_r) begin
            product_r <= sum_s;
            acc_ovf_r <= ovf_base_s | add_overflow(base_s, result_s, signed_r);
          end else begin
            product_r <= result_s;
            acc_ovf_r <= 1'b0;
          end
          done_r  <= 1'b1;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.product = product_r;
  assign bus.ready   = ready_r;
  assign bus.done    = done_r;
  assign bus.acc_ovf = acc_ovf_r;
endmodule

// File: tb/tb_asmd_mult_acc.sv
// Directed bench for asmd_mult_acc, W=10. dut_ee has early exit enabled,
// dut_fw always runs W MUL cycles. Expected values are hand-computed.
module tb_asmd_mult_acc;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   sel_fw;

  asmd_mult_acc_if #(.word_length(10)) if_ee ();
  asmd_mult_acc_if #(.word_length(10)) if_fw ();

  asmd_mult_acc #(.word_length(10), .early_exit(1'b1)) dut_ee (
    .clk(clk), .reset(reset), .bus(if_ee.slave)
  );
  asmd_mult_acc #(.word_length(10), .early_exit(1'b0)) dut_fw (
    .clk(clk), .reset(reset), .bus(if_fw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] cur_product();
    return sel_fw ? if_fw.product : if_ee.product;
  endfunction
  function automatic logic cur_ready();
    return sel_fw ? if_fw.ready : if_ee.ready;
  endfunction
  function automatic logic cur_done();
    return sel_fw ? if_fw.done : if_ee.done;
  endfunction
  function automatic logic cur_ovf();
    return sel_fw ? if_fw.acc_ovf : if_ee.acc_ovf;
  endfunction

  task automatic set_inputs(input logic [9:0] w0, input logic [9:0] w1,
                            input bit sm, input bit acc, input bit clr);
    if_ee.word0 = w0;  if_fw.word0 = w0;
    if_ee.word1 = w1;  if_fw.word1 = w1;
    if_ee.signed_mode = sm;  if_fw.signed_mode = sm;
    if_ee.accumulate  = acc; if_fw.accumulate  = acc;
    if_ee.clear_acc   = clr; if_fw.clear_acc   = clr;
  endtask

  task automatic set_start(input bit fw, input bit val);
    if_ee.start = val & ~fw;
    if_fw.start = val & fw;
  endtask

  // One operation: start, wait for done, check latency/product/flags.
  task automatic run_op(input string tag, input bit fw, input logic [9:0] w0,
                        input logic [9:0] w1, input bit sm, input bit acc, input bit clr,
                        input bit poke, input logic [19:0] exp_prod, input bit exp_ovf,
                        input int exp_lat);
    logic [19:0] prev;
    int          n;
    bit          seen;
    bit          hold_bad;
    sel_fw   = fw;
    prev     = cur_product();
    n        = 0;
    seen     = 1'b0;
    hold_bad = 1'b0;
    set_inputs(w0, w1, sm, acc, clr);
    set_start(fw, 1'b1);
    tick();
    set_start(fw, 1'b0);
    set_inputs(~w0, ~w1, ~sm, ~acc, 1'b0);
    chk({tag, " ready0"}, {31'd0, cur_ready()}, 32'd0);
    chk({tag, " done0"}, {31'd0, cur_done()}, 32'd0);
    while (!seen && n < 30) begin
      if (poke && n == 1) begin
        if_ee.word0 = 10'd7; if_fw.word0 = 10'd7;
        if_ee.word1 = 10'd7; if_fw.word1 = 10'd7;
        set_start(fw, 1'b1);
      end
      tick();
      n++;
      if (poke && n == 2) set_start(fw, 1'b0);
      if (cur_done()) seen = 1'b1;
      else if (cur_product() !== prev) hold_bad = 1'b1;
    end
    chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " product"}, {12'd0, cur_product()}, {12'd0, exp_prod});
    chk({tag, " acc_ovf"}, {31'd0, cur_ovf()}, {31'd0, exp_ovf});
    chk({tag, " ready"}, {31'd0, cur_ready()}, 32'd1);
    chk({tag, " hold"}, {31'd0, hold_bad}, 32'd0);
  endtask

  initial begin
    int  k;
    bit  late_done;
    checks = 0;
    errors = 0;
    sel_fw = 1'b0;
    reset  = 1'b1;
    set_inputs(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    set_start(1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst product", {12'd0, if_ee.product}, 32'd0);
    chk("rst ready", {31'd0, if_ee.ready}, 32'd1);
    chk("rst done", {31'd0, if_ee.done}, 32'd0);
    chk("rst acc_ovf", {31'd0, if_ee.acc_ovf}, 32'd0);
    chk("rst fw ready", {31'd0, if_fw.ready}, 32'd1);

    run_op("u4x5", 1'b0, 10'd4, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 20'd20, 1'b0, 4);
    run_op("u15x15", 1'b1, 10'd15, 10'd15, 1'b0, 1'b0, 1'b0, 1'b0, 20'd225, 1'b0, 11);
    tick();
    chk("u15x15 done_one_cycle", {31'd0, if_fw.done}, 32'd0);

    run_op("s-3x7", 1'b0, 10'h3FD, 10'd7, 1'b1, 1'b0, 1'b0, 1'b0, 20'd1048555, 1'b0, 4);
    run_op("s3x7acc", 1'b0, 10'd3, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0, 1'b0, 4);
    run_op("s-512sq", 1'b0, 10'h200, 10'h200, 1'b1, 1'b0, 1'b0, 1'b0, 20'd262144, 1'b0, 11);
    run_op("s-512sq_acc", 1'b0, 10'h200, 10'h200, 1'b1, 1'b1, 1'b0, 1'b0, 20'd524288, 1'b1, 11);
    run_op("u1023", 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 20'd1046529, 1'b0, 11);
    run_op("u1023acc", 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b0, 1'b0, 20'd1044482, 1'b1, 11);
    run_op("u1x1_sticky", 1'b0, 10'd1, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 20'd1044483, 1'b1, 2);
    run_op("clr_start_acc", 1'b0, 10'd4, 10'd5, 1'b0, 1'b1, 1'b1, 1'b0, 20'd20, 1'b0, 4);

    if_ee.clear_acc = 1'b1;
    tick();
    if_ee.clear_acc = 1'b0;
    chk("clear product", {12'd0, if_ee.product}, 32'd0);
    chk("clear acc_ovf", {31'd0, if_ee.acc_ovf}, 32'd0);

    run_op("u2x3", 1'b0, 10'd2, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 20'd6, 1'b0, 3);
    run_op("ee_w1_0", 1'b0, 10'd37, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 1'b0, 2);
    run_op("ee_w1_1", 1'b0, 10'd37, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd37, 1'b0, 2);

    run_op("fw_u3x9", 1'b1, 10'd3, 10'd9, 1'b0, 1'b0, 1'b0, 1'b0, 20'd27, 1'b0, 11);
    run_op("poke_mul", 1'b1, 10'd15, 10'd15, 1'b0, 1'b0, 1'b0, 1'b1, 20'd225, 1'b0, 11);

    // Reset in the middle of a MUL phase on the full-length instance.
    sel_fw = 1'b1;
    set_inputs(10'd15, 10'd15, 1'b0, 1'b0, 1'b0);
    set_start(1'b1, 1'b1);
    tick();
    set_start(1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst product", {12'd0, if_fw.product}, 32'd0);
    chk("midrst ready", {31'd0, if_fw.ready}, 32'd1);
    chk("midrst done", {31'd0, if_fw.done}, 32'd0);
    late_done = 1'b0;
    for (k = 0; k < 15; k++) begin
      tick();
      if (if_fw.done) late_done = 1'b1;
    end
    chk("midrst no_done", {31'd0, late_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/asmd_mult_acc.md
# asmd_mult_acc

Parametrised sequential shift-add multiplier-accumulator, the next generation of the team's ASMD multiplier. It keeps the start/ready handshake and adds the following: signed or unsigned operands, selected per operation; optional accumulation into the product register, with a sticky overflow flag; a one-cycle done pulse; and optional early termination when the remaining multiplier bits are zero. It sits beside the datapath as a multi-cycle arithmetic unit driven by a controller FSM.

## Interface
- word_length, 10, operand width W (≥2); product/accumulator width is 2W
- early_exit, 1, 1 = terminate MUL as soon as the remaining multiplier bits are zero; 0 = always W MUL cycles
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- word0  input  W  multiplicand, sampled on start edge
- word1  input  W  multiplier, sampled on start edge
- start  input  1  begin operation; honoured only when ready=1
- signed_mode  input  1  1 = two's-complement operands/result; sampled with start
- accumulate  input  1  1 = product <= product + result; 0 = product <= result; sampled with start
- clear_acc  input  1  in IDLE, zero product and acc_ovf at next edge
- product  output  2W  result/accumulator register; stable while busy
- ready  output  1  high in IDLE
- done  output  1  one-cycle pulse when product updates
- acc_ovf  output  1  sticky accumulation overflow

## Operation
- States: IDLE, MUL, FIX.
- IDLE: ready=1.
  - start=1 latches the operands and the mode bits, and moves to MUL.
  - In signed mode the magnitudes |word0| and |word1| are latched, held in W unsigned bits; -2^(W-1) maps to 2^(W-1). A negate flag is set to sign(word0) XOR sign(word1).
- MUL: one multiplier bit per cycle, LSB first.
  - If the bit is 1, the shifted multiplicand is added into a 2W partial register.
  - The multiplier then shifts right.
  - Leave for FIX after the W-th bit. If early_exit=1, also leave once the shifted multiplier is zero; at least one MUL cycle always runs.
- FIX:
  - result = negate ? -partial : partial, mod 2^(2W).
  - product <= accumulate ? product + result : result, mod 2^(2W).
  - Then go to IDLE and pulse done.
- acc_ovf, set only on accumulate ops:
  - unsigned mode: carry out of bit 2W-1;
  - signed mode: both addends share a sign and the sum differs in sign.
  - acc_ovf stays set (sticky) until cleared.
  - A non-accumulate op clears acc_ovf to 0.
- clear_acc is ignored outside IDLE. If start and clear_acc are both high in IDLE, the accumulation base is zero and acc_ovf is cleared before any new overflow is evaluated.
- start outside IDLE is ignored and is not queued.
- The operand inputs may change freely after the start edge.

## Timing
- Reset values: product=0, ready=1, done=0, acc_ovf=0, state=IDLE. Reset mid-operation aborts to these values at the next edge.
- Edge 0 samples start. ready=0 from edge 0 onward.
- MUL occupies edges 1..N:
  - N=W when early_exit=0;
  - otherwise N = max(1, index of MSB of |word1| + 1).
- Edge N+1 (FIX): product, acc_ovf and done=1 update together, and ready=1.
- Start-to-ready latency is N+1 cycles (W+1 worst case).
- done is high for exactly one cycle. A new start may be sampled on the same edge that done falls, giving back-to-back operations.
- product holds its previous value from edge 0 through edge N.

## Test plan
- W=10, unsigned, 4×5, accumulate=0, early_exit=1: product=20 on done; N=3, so ready returns 4 cycles after start.
- Unsigned 15×15, early_exit=0: product=225; ready returns 11 cycles after start; done high for exactly one cycle.
- Signed -3×7: product=1048555 (-21 mod 2^20). Signed -512×-512: product=262144. acc_ovf=0 in both.
- Unsigned 1023×1023, accumulate=0, then accumulate=1 with the same operands: product 1046529, then 1044482; acc_ovf=1 after the second op. A later clear_acc gives product=0, acc_ovf=0.
- Early exit, word1=0 then word1=1: ready returns 2 cycles after start in both cases; products 0 and word0.
- start pulsed during MUL: ignored, and the first result is unchanged. reset asserted mid-MUL: next edge product=0, ready=1, done=0, with no done pulse afterwards.
